// File: rtl/exec_stage.sv
// Execute stage: operand select, B pre-shift, 8-op ALU with a shift-add multiply,
// and registered C/status outputs behind a valid/ready handshake.
module exec_stage #(
  parameter int WIDTH = 16,
  parameter int IMM_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [IMM_W-1:0] imm,
  input  logic             asel,
  input  logic             bsel,
  input  logic [1:0]       shift,
  input  logic [2:0]       aluop,
  input  logic             loadc,
  input  logic             loads,
  output logic [WIDTH-1:0] C,
  output logic [2:0]       status,
  output logic             out_valid,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_MUL = 1'b1} state_t;

  state_t           state_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] mcand_r;
  logic [WIDTH-1:0] mplier_r;
  logic [WIDTH-1:0] acc_r;
  logic [WIDTH-1:0] c_r;
  logic [2:0]       status_r;
  logic             loadc_r;
  logic             loads_r;
  logic             out_valid_r;

  logic [WIDTH-1:0] ain_s;
  logic [WIDTH-1:0] bsh_s;
  logic [WIDTH-1:0] bin_s;
  logic [WIDTH-1:0] res_s;
  logic [WIDTH-1:0] acc_nxt_s;
  logic             v_s;
  logic             accept_s;

  // {V, N, Z} from a result and its overflow bit
  function automatic logic [2:0] calc_flags(input logic v, input logic [WIDTH-1:0] r);
    return {v, r[WIDTH-1], (r == {WIDTH{1'b0}})};
  endfunction

  assign in_ready  = (state_r == ST_IDLE);
  assign busy      = (state_r == ST_MUL);
  assign C         = c_r;
  assign status    = status_r;
  assign out_valid = out_valid_r;
  assign accept_s  = in_valid && (state_r == ST_IDLE);

  // Operand selection and B pre-shift
  always_comb begin
    ain_s = {WIDTH{1'b0}};
    bsh_s = B;
    bin_s = B;
    if (asel) begin
      ain_s = A;
    end else begin
      ain_s = {WIDTH{1'b0}};
    end
    case (shift)
      2'b00:   bsh_s = B;
      2'b01:   bsh_s = {B[WIDTH-2:0], 1'b0};
      2'b10:   bsh_s = {1'b0, B[WIDTH-1:1]};
      2'b11:   bsh_s = {B[WIDTH-1], B[WIDTH-1:1]};
      default: bsh_s = B;
    endcase
    if (bsel) begin
      bin_s = {{(WIDTH-IMM_W){1'b0}}, imm};
    end else begin
      bin_s = bsh_s;
    end
  end

  // Single-cycle ALU; MUL result comes from the iterative datapath instead
  always_comb begin
    res_s = {WIDTH{1'b0}};
    v_s   = 1'b0;
    case (aluop)
      3'b000: begin
        res_s = ain_s + bin_s;
        v_s   = (ain_s[WIDTH-1] == bin_s[WIDTH-1]) && (res_s[WIDTH-1] != ain_s[WIDTH-1]);
      end
      3'b001: begin
        res_s = ain_s - bin_s;
        v_s   = (ain_s[WIDTH-1] != bin_s[WIDTH-1]) && (res_s[WIDTH-1] != ain_s[WIDTH-1]);
      end
      3'b010:  res_s = ain_s & bin_s;
      3'b011:  res_s = ~bin_s;
      3'b100:  res_s = ain_s | bin_s;
      3'b101:  res_s = ain_s ^ bin_s;
      3'b110:  res_s = {WIDTH{1'b0}};
      3'b111:  res_s = bin_s;
      default: res_s = {WIDTH{1'b0}};
    endcase
  end

  // One shift-add step: add the shifted multiplicand when the multiplier LSB is set
  always_comb begin
    if (mplier_r[0]) begin
      acc_nxt_s = acc_r + mcand_r;
    end else begin
      acc_nxt_s = acc_r;
    end
  end

  // Handshake FSM, multiply iteration and result/status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      cnt_r       <= {CW{1'b0}};
      mcand_r     <= {WIDTH{1'b0}};
      mplier_r    <= {WIDTH{1'b0}};
      acc_r       <= {WIDTH{1'b0}};
      c_r         <= {WIDTH{1'b0}};
      status_r    <= 3'b000;
      loadc_r     <= 1'b0;
      loads_r     <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          out_valid_r <= 1'b0;
          if (accept_s) begin
            if (aluop == 3'b110) begin
              state_r  <= ST_MUL;
              cnt_r    <= CW'(WIDTH);
              mcand_r  <= ain_s;
              mplier_r <= bin_s;
              acc_r    <= {WIDTH{1'b0}};
              loadc_r  <= loadc;
              loads_r  <= loads;
            end else begin
              out_valid_r <= 1'b1;
              if (loadc) c_r <= res_s;
              if (loads) status_r <= calc_flags(v_s, res_s);
            end
          end
        end
        ST_MUL: begin
          acc_r       <= acc_nxt_s;
          mcand_r     <= {mcand_r[WIDTH-2:0], 1'b0};
          mplier_r    <= {1'b0, mplier_r[WIDTH-1:1]};
          cnt_r       <= cnt_r - CW'(1);
          out_valid_r <= 1'b0;
          if (cnt_r == CW'(1)) begin
            state_r     <= ST_IDLE;
            out_valid_r <= 1'b1;
            if (loadc_r) c_r <= acc_nxt_s;
            if (loads_r) status_r <= calc_flags(1'b0, acc_nxt_s);
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exec_stage.sv
// Scoreboard bench for exec_stage: directed vectors push expected {C,status},
// monitors pop and compare on every out_valid pulse (16-bit and 8-bit instances).
module tb_exec_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;

  logic        in_valid = 1'b0;
  logic [15:0] a = 16'h0, b = 16'h0;
  logic [4:0]  imm = 5'h0;
  logic        asel = 1'b1, bsel = 1'b0;
  logic [1:0]  shift = 2'b00;
  logic [2:0]  aluop = 3'b000;
  logic        loadc = 1'b0, loads = 1'b0;
  logic [15:0] c;
  logic [2:0]  status;
  logic        in_ready, out_valid, busy;

  logic        in_valid8 = 1'b0;
  logic [7:0]  a8 = 8'h0, b8 = 8'h0;
  logic [2:0]  aluop8 = 3'b000;
  logic [7:0]  c8;
  logic [2:0]  status8;
  logic        in_ready8, out_valid8, busy8;

  int errors = 0;
  int checks = 0;

  logic [18:0] q16[$];
  logic [10:0] q8[$];
  logic [15:0] mc = 16'h0;
  logic [2:0]  ms = 3'b000;

  always #5 clk = ~clk;

  exec_stage #(.WIDTH(16), .IMM_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(a), .B(b), .imm(imm), .asel(asel), .bsel(bsel), .shift(shift),
    .aluop(aluop), .loadc(loadc), .loads(loads), .C(c), .status(status),
    .out_valid(out_valid), .busy(busy)
  );

  exec_stage #(.WIDTH(8), .IMM_W(5)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .A(a8), .B(b8), .imm(5'h00), .asel(1'b1), .bsel(1'b0), .shift(2'b00),
    .aluop(aluop8), .loadc(1'b1), .loads(1'b1), .C(c8), .status(status8),
    .out_valid(out_valid8), .busy(busy8)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // 16-bit scoreboard monitor
  always @(negedge clk) begin
    if (out_valid) begin
      logic [18:0] e;
      checks++;
      if (q16.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out_valid16: C=0x%0h status=%b with nothing pending", c, status);
      end else begin
        e = q16.pop_front();
        if ({c, status} !== e) begin
          errors++;
          $display("FAIL result16: got C=0x%0h status=%b, expected C=0x%0h status=%b",
                   c, status, e[18:3], e[2:0]);
        end
      end
    end
  end

  // 8-bit scoreboard monitor
  always @(negedge clk) begin
    if (out_valid8) begin
      logic [10:0] e;
      checks++;
      if (q8.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out_valid8: C=0x%0h status=%b with nothing pending", c8, status8);
      end else begin
        e = q8.pop_front();
        if ({c8, status8} !== e) begin
          errors++;
          $display("FAIL result8: got C=0x%0h status=%b, expected C=0x%0h status=%b",
                   c8, status8, e[10:3], e[2:0]);
        end
      end
    end
  end

  task automatic op16(input logic [15:0] ta, input logic [15:0] tb, input logic [4:0] ti,
                      input logic tas, input logic tbs, input logic [1:0] tsh,
                      input logic [2:0] top, input logic tlc, input logic tls,
                      input logic [15:0] res, input logic [2:0] st);
    @(negedge clk);
    a = ta; b = tb; imm = ti; asel = tas; bsel = tbs; shift = tsh;
    aluop = top; loadc = tlc; loads = tls; in_valid = 1'b1;
    if (tlc) mc = res;
    if (tls) ms = st;
    q16.push_back({mc, ms});
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1;
    check("reset_C", 32'(c), 32'h0);
    check("reset_status", 32'(status), 32'h0);
    check("reset_in_ready", 32'(in_ready), 32'h1);
    check("reset_out_valid", 32'(out_valid), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    #1 rst_n = 1'b1;

    op16(16'h7FFF, 16'h0001, 5'h00, 1'b1, 1'b0, 2'b00, 3'b000, 1'b1, 1'b1, 16'h8000, 3'b110);
    check("add_out_valid_timing", 32'(out_valid), 32'h1);
    op16(16'h1234, 16'h1234, 5'h00, 1'b1, 1'b0, 2'b00, 3'b001, 1'b1, 1'b1, 16'h0000, 3'b001);
    op16(16'h1234, 16'h1234, 5'b10101, 1'b0, 1'b1, 2'b00, 3'b111, 1'b1, 1'b0, 16'h0015, 3'b000);
    op16(16'h0000, 16'h8002, 5'h00, 1'b1, 1'b0, 2'b11, 3'b111, 1'b1, 1'b1, 16'hC001, 3'b010);
    op16(16'h0000, 16'h8002, 5'h00, 1'b1, 1'b0, 2'b10, 3'b111, 1'b1, 1'b1, 16'h4001, 3'b000);
    op16(16'h0000, 16'h8002, 5'h00, 1'b1, 1'b0, 2'b01, 3'b111, 1'b1, 1'b1, 16'h0004, 3'b000);
    op16(16'h0001, 16'h0001, 5'h00, 1'b1, 1'b0, 2'b00, 3'b000, 1'b0, 1'b0, 16'h0002, 3'b000);
    op16(16'hFFFF, 16'h0001, 5'h00, 1'b1, 1'b0, 2'b00, 3'b000, 1'b0, 1'b1, 16'h0000, 3'b001);
    op16(16'hF0F0, 16'hFF00, 5'h00, 1'b1, 1'b0, 2'b00, 3'b010, 1'b1, 1'b1, 16'hF000, 3'b010);
    op16(16'h00F0, 16'h000F, 5'h00, 1'b1, 1'b0, 2'b00, 3'b100, 1'b1, 1'b1, 16'h00FF, 3'b000);
    op16(16'hFFFF, 16'h0F0F, 5'h00, 1'b1, 1'b0, 2'b00, 3'b101, 1'b1, 1'b1, 16'hF0F0, 3'b010);
    op16(16'h1234, 16'h00FF, 5'h00, 1'b1, 1'b0, 2'b00, 3'b011, 1'b1, 1'b1, 16'hFF00, 3'b010);
    op16(16'h8000, 16'h0001, 5'h00, 1'b1, 1'b0, 2'b00, 3'b001, 1'b1, 1'b1, 16'h7FFF, 3'b100);
    op16(16'h1234, 16'h0001, 5'h00, 1'b0, 1'b0, 2'b00, 3'b001, 1'b1, 1'b1, 16'hFFFF, 3'b010);
    op16(16'h0010, 16'hAAAA, 5'h1F, 1'b1, 1'b1, 2'b00, 3'b000, 1'b1, 1'b1, 16'h002F, 3'b000);

    // 16-bit MUL: busy window, ignored requests, operand changes after accept
    op16(16'h0003, 16'hFFFF, 5'h00, 1'b1, 1'b0, 2'b00, 3'b110, 1'b1, 1'b1, 16'hFFFD, 3'b010);
    for (int i = 1; i <= 16; i++) begin
      check("mul_in_ready_low", 32'(in_ready), 32'h0);
      check("mul_busy_high", 32'(busy), 32'h1);
      check("mul_no_early_valid", 32'(out_valid), 32'h0);
      a = 16'h0000; b = 16'h0000; aluop = 3'b000;
      in_valid = (i <= 10) ? 1'b1 : 1'b0;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check("mul_done_in_ready", 32'(in_ready), 32'h1);
    check("mul_done_busy", 32'(busy), 32'h0);
    check("mul_out_valid_timing", 32'(out_valid), 32'h1);

    // 8-bit MUL
    @(negedge clk);
    a8 = 8'h0F; b8 = 8'h11; aluop8 = 3'b110; in_valid8 = 1'b1;
    q8.push_back({8'hFF, 3'b010});
    @(posedge clk);
    #1 in_valid8 = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check("mul8_busy_before_done", 32'(busy8), 32'h1);
    check("mul8_no_early_valid", 32'(out_valid8), 32'h0);
    @(posedge clk);
    #1;
    check("mul8_busy_done", 32'(busy8), 32'h0);
    check("mul8_out_valid_timing", 32'(out_valid8), 32'h1);

    // Reset in the middle of a multiply: no completion may appear
    @(negedge clk);
    a = 16'h0007; b = 16'h0009; asel = 1'b1; bsel = 1'b0; shift = 2'b00;
    aluop = 3'b110; loadc = 1'b1; loads = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    check("mid_mul_busy", 32'(busy), 32'h1);
    repeat (6) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_C", 32'(c), 32'h0);
    check("midreset_status", 32'(status), 32'h0);
    check("midreset_busy", 32'(busy), 32'h0);
    check("midreset_in_ready", 32'(in_ready), 32'h1);
    check("midreset_out_valid", 32'(out_valid), 32'h0);
    mc = 16'h0; ms = 3'b000;
    @(negedge clk) rst_n = 1'b1;
    repeat (20) @(posedge clk);

    op16(16'h0002, 16'h0003, 5'h00, 1'b1, 1'b0, 2'b00, 3'b000, 1'b1, 1'b1, 16'h0005, 3'b000);
    check("post_reset_add_valid", 32'(out_valid), 32'h1);
    check("post_reset_add_C", 32'(c), 32'h5);
    repeat (3) @(posedge clk);
    #1;
    check("q16_drained", 32'(q16.size()), 32'h0);
    check("q8_drained", 32'(q8.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/exec_stage.md
# exec_stage

Parametrised execute stage for the RISC datapath. It selects operands, pre-shifts B and applies an 8-op ALU, including a multi-cycle shift-add multiply. It writes the C result register and a 3-bit status register (V, N, Z) behind a valid/ready handshake. It sits between register-file read and writeback, and generalises the 16-bit single-cycle computation stage to any width, with more ops and flow control.

## Interface
Parameters:
- WIDTH, 16, datapath width (≥4)
- IMM_W, 5, immediate width (< WIDTH), zero-extended

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operation request
- in_ready  out  1  stage can accept; high iff state IDLE
- A  in  WIDTH  operand A
- B  in  WIDTH  operand B
- imm  in  IMM_W  immediate
- asel  in  1  1: Ain=A; 0: Ain=0
- bsel  in  1  1: Bin=zero-extended imm; 0: Bin=shifted B
- shift  in  2  B pre-shift: 00 none, 01 LSL1 (fill 0), 10 LSR1 (fill 0), 11 ASR1 (fill B[MSB])
- aluop  in  3  000 ADD, 001 SUB (Ain−Bin), 010 AND, 011 NOT Bin, 100 OR, 101 XOR, 110 MUL, 111 MOV Bin
- loadc  in  1  write C at completion
- loads  in  1  write status at completion
- C  out  WIDTH  result register
- status  out  3  {V, N, Z}
- out_valid  out  1  one-cycle completion pulse
- busy  out  1  high while state MUL

## Operation
- Accept: in_valid && in_ready at a rising edge.
  - All inputs are sampled at that edge; later input changes are ignored.
  - in_valid while busy is ignored, not queued.
- Single-cycle ops (all except 110): result computed from the sampled inputs; completion at the accept edge.
- MUL: unsigned shift-add over WIDTH bits; result is the low WIDTH bits of Ain×Bin.
  - Multiplicand Ain and multiplier Bin are latched at accept; one multiplier bit is processed per cycle.
  - loadc and loads are latched at accept.
- Flags, computed from the WIDTH-bit result:
  - Z = (result == 0)
  - N = result[WIDTH-1]
  - V, ADD: Ain and Bin have equal signs and the result sign differs
  - V, SUB: Ain and Bin have different signs and the result sign differs from Ain
  - V = 0 for all other ops, including MUL
- Completion:
  - C ← result if loadc, else C holds.
  - status ← {V,N,Z} if loads, else status holds.
  - out_valid pulses regardless of loadc/loads.
- Arithmetic wraps modulo 2^WIDTH; no carry output.
- FSM:
  - IDLE --accept, aluop≠110--> IDLE (complete)
  - IDLE --accept MUL--> MUL (counter = WIDTH)
  - MUL: counter decrements each edge; the edge where counter goes 1→0 completes and returns to IDLE.
- Reset (async, any state, including mid-MUL):
  - state IDLE, counter 0
  - C = 0, status = 3'b000
  - out_valid = 0, busy = 0, in_ready = 1
  - a partial product is discarded.

## Timing
- Single-cycle op accepted at edge k:
  - C/status update at edge k.
  - out_valid is high for the cycle after edge k.
  - in_ready stays high, so back-to-back ops can be accepted every cycle.
- MUL accepted at edge k:
  - in_ready low and busy high from edge k to edge k+WIDTH.
  - Iterations occur at edges k+1..k+WIDTH; C/status update at edge k+WIDTH.
  - out_valid is high for the cycle after edge k+WIDTH.
  - The next accept is possible at edge k+WIDTH+1.
  - Total latency is WIDTH+1 edges.
- out_valid is registered and never high two cycles running for one operation.
- C and status are registered outputs; no combinational path from inputs to them.

## Test plan
- Reset: assert rst_n=0 asynchronously mid-cycle → C=0, status=000, in_ready=1, out_valid=0 immediately.
- ADD overflow (WIDTH=16):
  - Stimulus: A=0x7FFF, B=0x0001, asel=1, bsel=0, shift=00, aluop=000, loadc=loads=1.
  - Response: C=0x8000 and status=110 one edge later; out_valid pulses once.
- SUB, then immediate MOV:
  - SUB with A=B=0x1234 → C=0, status=001.
  - Next cycle, asel=0, bsel=1, imm=5'b10101, aluop=111, loadc=1, loads=0 → C=0x0015, status stays 001.
- Shifts and masking: B=0x8002, aluop=111.
  - shift=11 → C=0xC001; shift=10 → 0x4001; shift=01 → 0x0004.
  - A second op with loadc=0 leaves C unchanged while out_valid still pulses.
- MUL (WIDTH=16):
  - Stimulus: A=0x0003, B=0xFFFF, aluop=110, loadc=loads=1.
  - Response:
    - in_ready low for 16 edges; in_valid pulses during busy are ignored.
    - A/B changed after accept do not affect the result.
    - C=0xFFFD and status=010 at edge k+16; out_valid at cycle k+16.
  - Repeat with WIDTH=8: 0x0F×0x11 → C=0xFF.
- Reset mid-MUL: assert rst_n=0 at iteration 7 → C=0, busy=0, no out_valid pulse.
  - Following ADD 2+3 → C=0x0005 with normal timing.
